// File: rtl/spi_frame_pkg.sv
// Shared types and CRC-8 helper for the SPI frame receiver.
package spi_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECV   = 2'd1,
        ST_CHECK  = 2'd2,
        ST_COMMIT = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_SHORT = 2'd1,
        ERR_LONG  = 2'd2,
        ERR_CRC   = 2'd3
    } err_code_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    // One CRC-8 step over a whole byte, MSB first, no reflection.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Oversampling synchronisers for the SPI pins plus rising-edge detection,
// all frozen while clk_en_i is low.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic clk_en_i,
    input  logic cs_i,
    input  logic sclk_i,
    input  logic mosi_i,
    output logic cs_s_o,
    output logic mosi_s_o,
    output logic cs_rise_o,
    output logic sclk_rise_o
);

    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   cs_prev_q;
    logic                   sclk_prev_q;

    // Pure data path: no reset, the chain refills from the pins within a few cycles.
    always_ff @(posedge clk_i) begin
        if (clk_en_i) begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
        end
    end

    assign cs_s_o      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s_o    = mosi_sync_q[SYNC_STAGES-1];
    assign cs_rise_o   = cs_sync_q[SYNC_STAGES-1] & ~cs_prev_q;
    assign sclk_rise_o = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI-slave frame receiver with shadow/output double buffering and a
// retriggerable time-update flag. Define SPI_FRAME_CRC_EN to append a CRC-8 byte.
module spi_frame_rx
    import spi_frame_pkg::*;
#(
    parameter int FRAME_BYTES = 51,
    parameter int TIME_BYTES  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int UPD_HOLD    = 128
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clk_en,
    input  logic                     MOSI,
    input  logic                     CS,
    input  logic                     SCLK,
    output logic [8*FRAME_BYTES-1:0] FRAME,
    output logic                     FRAME_WR,
    output logic                     SYS_TIME_UPDATE,
    output logic                     FRAME_ERR,
    output logic [1:0]               ERR_CODE,
    output logic [7:0]               ERR_CNT
);

`ifdef SPI_FRAME_CRC_EN
    localparam int EXP = FRAME_BYTES + 1;
`else
    localparam int EXP = FRAME_BYTES;
`endif
    localparam int CNT_W = $clog2(EXP + 2);
    localparam int IDX_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

    localparam logic [CNT_W-1:0] FB_C   = CNT_W'(FRAME_BYTES);
    localparam logic [CNT_W-1:0] EXP_C  = CNT_W'(EXP);
    localparam logic [CNT_W-1:0] EXP1_C = CNT_W'(EXP + 1);

    logic cs_s;
    logic mosi_s;
    logic cs_rise;
    logic sclk_rise;

    spi_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i       (clk),
        .clk_en_i    (clk_en),
        .cs_i        (CS),
        .sclk_i      (SCLK),
        .mosi_i      (MOSI),
        .cs_s_o      (cs_s),
        .mosi_s_o    (mosi_s),
        .cs_rise_o   (cs_rise),
        .sclk_rise_o (sclk_rise)
    );

    rx_state_t              state_q;
    logic                   armed_q;
    logic [2:0]             bit_cnt_q;
    logic [CNT_W-1:0]       byte_cnt_q;
    logic                   ovf_q;
    err_code_t              err_q;
    logic [7:0]             shift_q;
    logic [7:0]             shadow_q [FRAME_BYTES];

    logic [8*FRAME_BYTES-1:0] frame_q;
    logic                     frame_wr_q;
    logic                     frame_err_q;
    err_code_t                err_code_q;
    logic [7:0]               err_cnt_q;
    logic                     upd_q;
    logic [7:0]               timer_q;

`ifdef SPI_FRAME_CRC_EN
    logic [7:0] crc_q;
    logic [7:0] rx_crc_q;
`endif

    logic [7:0] byte_d;
    logic       byte_done;
    logic       time_nz;
    err_code_t  chk_err_d;

    assign byte_d    = {shift_q[6:0], mosi_s};
    assign byte_done = (state_q == ST_RECV) && sclk_rise && (bit_cnt_q == 3'd7);

    always_comb begin
        time_nz = 1'b0;
        for (int i = 0; i < TIME_BYTES; i++) begin
            time_nz = time_nz | (|shadow_q[i]);
        end
    end

    // Overlong wins over short, which wins over a CRC mismatch.
    always_comb begin
        chk_err_d = ERR_NONE;
        if (ovf_q) begin
            chk_err_d = ERR_LONG;
        end else if ((bit_cnt_q != 3'd0) || (byte_cnt_q < EXP_C)) begin
            chk_err_d = ERR_SHORT;
`ifdef SPI_FRAME_CRC_EN
        end else if (crc_q != rx_crc_q) begin
            chk_err_d = ERR_CRC;
`endif
        end
    end

    // Byte assembly and shadow buffer: data only, no reset.
    always_ff @(posedge clk) begin
        if (clk_en) begin
            if ((state_q == ST_RECV) && sclk_rise) begin
                shift_q <= byte_d;
            end
            if (byte_done && (byte_cnt_q < FB_C)) begin
                shadow_q[byte_cnt_q[IDX_W-1:0]] <= byte_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            armed_q     <= 1'b0;
            bit_cnt_q   <= 3'd0;
            byte_cnt_q  <= '0;
            ovf_q       <= 1'b0;
            err_q       <= ERR_NONE;
            frame_q     <= '0;
            frame_wr_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_cnt_q   <= 8'd0;
            upd_q       <= 1'b0;
            timer_q     <= 8'd0;
`ifdef SPI_FRAME_CRC_EN
            crc_q       <= 8'd0;
            rx_crc_q    <= 8'd0;
`endif
        end else if (clk_en) begin
            frame_wr_q  <= 1'b0;
            frame_err_q <= 1'b0;

            // A frame may only start after CS has been seen high.
            if (cs_s) begin
                armed_q <= 1'b1;
            end

            if (timer_q != 8'd0) begin
                timer_q <= timer_q - 8'd1;
                upd_q   <= (timer_q != 8'd1);
            end

            case (state_q)
                ST_IDLE: begin
                    bit_cnt_q  <= 3'd0;
                    byte_cnt_q <= '0;
                    ovf_q      <= 1'b0;
`ifdef SPI_FRAME_CRC_EN
                    crc_q      <= 8'd0;
`endif
                    if (!cs_s && armed_q) begin
                        armed_q <= 1'b0;
                        state_q <= ST_RECV;
                    end
                end

                ST_RECV: begin
                    if (sclk_rise) begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
`ifdef SPI_FRAME_CRC_EN
                            if (byte_cnt_q < FB_C) begin
                                crc_q <= crc8_byte(crc_q, byte_d);
                            end else if (byte_cnt_q == FB_C) begin
                                rx_crc_q <= byte_d;
                            end
`endif
                            if (byte_cnt_q != EXP1_C) begin
                                byte_cnt_q <= byte_cnt_q + 1'b1;
                            end
                            if (byte_cnt_q == EXP_C) begin
                                ovf_q <= 1'b1;
                            end
                        end
                    end
                    if (cs_rise) begin
                        state_q <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    err_q   <= chk_err_d;
                    state_q <= ST_COMMIT;
                end

                ST_COMMIT: begin
                    if (err_q == ERR_NONE) begin
                        for (int i = 0; i < FRAME_BYTES; i++) begin
                            frame_q[8*(FRAME_BYTES-1-i) +: 8] <= shadow_q[i];
                        end
                        frame_wr_q <= 1'b1;
                        err_code_q <= ERR_NONE;
                        if (time_nz) begin
                            upd_q   <= 1'b1;
                            timer_q <= 8'(UPD_HOLD);
                        end
                    end else begin
                        frame_err_q <= 1'b1;
                        err_code_q  <= err_q;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_q <= err_cnt_q + 8'd1;
                        end
                    end
                    state_q <= ST_IDLE;
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign FRAME           = frame_q;
    assign FRAME_WR        = frame_wr_q;
    assign FRAME_ERR       = frame_err_q;
    assign ERR_CODE        = err_code_q;
    assign ERR_CNT         = err_cnt_q;
    assign SYS_TIME_UPDATE = upd_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench: a 51-byte receiver for framing/error/reset cases and a
// 1-byte receiver for the time-flag retrigger case.
module tb_spi_frame_rx;

    localparam int FB  = 51;
    localparam int HP1 = 5;
    localparam int HP2 = 4;
`ifdef SPI_FRAME_CRC_EN
    localparam int XB = 1;
`else
    localparam int XB = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clk_en = 1'b1;
    logic cs1 = 1'b1, sclk1 = 1'b0, mosi1 = 1'b0;
    logic cs2 = 1'b1, sclk2 = 1'b0, mosi2 = 1'b0;

    logic [8*FB-1:0] frame1;
    logic            wr1, upd1, ferr1;
    logic [1:0]      ecode1;
    logic [7:0]      ecnt1;
    logic [7:0]      frame2;
    logic            wr2, upd2, ferr2;
    logic [1:0]      ecode2;
    logic [7:0]      ecnt2;

    spi_frame_rx #(
        .FRAME_BYTES (FB),
        .TIME_BYTES  (8),
        .SYNC_STAGES (2),
        .UPD_HOLD    (128)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clk_en          (clk_en),
        .MOSI            (mosi1),
        .CS              (cs1),
        .SCLK            (sclk1),
        .FRAME           (frame1),
        .FRAME_WR        (wr1),
        .SYS_TIME_UPDATE (upd1),
        .FRAME_ERR       (ferr1),
        .ERR_CODE        (ecode1),
        .ERR_CNT         (ecnt1)
    );

    spi_frame_rx #(
        .FRAME_BYTES (1),
        .TIME_BYTES  (1),
        .SYNC_STAGES (2),
        .UPD_HOLD    (128)
    ) u_dut_small (
        .clk             (clk),
        .rst_n           (rst_n),
        .clk_en          (clk_en),
        .MOSI            (mosi2),
        .CS              (cs2),
        .SCLK            (sclk2),
        .FRAME           (frame2),
        .FRAME_WR        (wr2),
        .SYS_TIME_UPDATE (upd2),
        .FRAME_ERR       (ferr2),
        .ERR_CODE        (ecode2),
        .ERR_CNT         (ecnt2)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int wr1_tot = 0;
    int upd2_low = 0;
    int cyc = 0;
    bit mon2 = 1'b0;
    logic [7:0] tx [0:63];

    always @(negedge clk) begin
        cyc     <= cyc + 1;
        wr1_tot <= wr1_tot + int'(wr1);
        if (mon2 && !upd2) upd2_low <= upd2_low + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] crc_ref(input int n);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[7] ^ tx[i][7-k];
                c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return c;
    endfunction

    task automatic seal_crc(input int n);
        tx[n] = crc_ref(n);
    endtask

    task automatic send_bits(input bit sel, input logic [7:0] b, input int n);
        int hp;
        hp = sel ? HP2 : HP1;
        for (int k = 0; k < n; k++) begin
            if (sel) mosi2 = b[7-k]; else mosi1 = b[7-k];
            repeat (hp) @(negedge clk);
            if (sel) sclk2 = 1'b1; else sclk1 = 1'b1;
            repeat (hp) @(negedge clk);
            if (sel) sclk2 = 1'b0; else sclk1 = 1'b0;
        end
    endtask

    task automatic send_frame(input bit sel, input int nbytes, input int xbits);
        int hp;
        hp = sel ? HP2 : HP1;
        if (sel) cs2 = 1'b0; else cs1 = 1'b0;
        repeat (hp) @(negedge clk);
        for (int i = 0; i < nbytes; i++) send_bits(sel, tx[i], 8);
        if (xbits > 0) send_bits(sel, tx[nbytes], xbits);
        repeat (hp) @(negedge clk);
        if (sel) cs2 = 1'b1; else cs1 = 1'b1;
    endtask

    task automatic wait_outcome(input bit sel, output bit got_wr, output bit got_err);
        got_wr  = 1'b0;
        got_err = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (sel ? wr2 : wr1) begin got_wr = 1'b1; break; end
            if (sel ? ferr2 : ferr1) begin got_err = 1'b1; break; end
        end
    endtask

    task automatic measure_upd(input bit sel, output int n);
        n = 0;
        while ((sel ? upd2 : upd1) && n < 400) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        bit gw, ge;
        int n, t_a;

        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_frame_zero", 32'(frame1 != '0), 32'd0);
        chk("rst_wr",         32'(wr1),    32'd0);
        chk("rst_upd",        32'(upd1),   32'd0);
        chk("rst_ferr",       32'(ferr1),  32'd0);
        chk("rst_ecode",      32'(ecode1), 32'd0);
        chk("rst_ecnt",       32'(ecnt1),  32'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Valid frame 0x01..0x33
        for (int i = 0; i < 64; i++) tx[i] = 8'(i + 1);
        seal_crc(FB);
        send_frame(1'b0, FB + XB, 0);
        wait_outcome(1'b0, gw, ge);
        chk("t1_wr",       32'(gw), 32'd1);
        chk("t1_byte0",    32'(frame1[407:400]), 32'h01);
        chk("t1_byte25",   32'(frame1[207:200]), 32'h1A);
        chk("t1_byte50",   32'(frame1[7:0]),     32'h33);
        chk("t1_ecode",    32'(ecode1), 32'd0);
        chk("t1_upd_rise", 32'(upd1),   32'd1);
        measure_upd(1'b0, n);
        chk("t1_upd_len",  32'(n), 32'd128);
        repeat (5) @(negedge clk);
        chk("t1_wr_pulses", 32'(wr1_tot), 32'd1);

        // Zero time field
        for (int i = 0; i < 64; i++) tx[i] = (i < 8) ? 8'h00 : 8'(i + 1);
        seal_crc(FB);
        send_frame(1'b0, FB + XB, 0);
        wait_outcome(1'b0, gw, ge);
        chk("t2_wr",     32'(gw), 32'd1);
        chk("t2_upd",    32'(upd1), 32'd0);
        chk("t2_byte0",  32'(frame1[407:400]), 32'h00);
        chk("t2_byte8",  32'(frame1[343:336]), 32'h09);
        chk("t2_byte50", 32'(frame1[7:0]),     32'h33);
        repeat (30) @(negedge clk);
        chk("t2_upd_later", 32'(upd1), 32'd0);
        chk("t2_wr_pulses", 32'(wr1_tot), 32'd2);

        // Short frames
        for (int i = 0; i < 64; i++) tx[i] = 8'hA0 ^ 8'(i);
        send_frame(1'b0, 50, 0);
        wait_outcome(1'b0, gw, ge);
        chk("t3_err",    32'(ge), 32'd1);
        chk("t3_ecode",  32'(ecode1), 32'd1);
        chk("t3_keep",   32'(frame1[343:336]), 32'h09);
        chk("t3_ecnt",   32'(ecnt1), 32'd1);
        repeat (10) @(negedge clk);
        send_frame(1'b0, FB, 3);
        wait_outcome(1'b0, gw, ge);
        chk("t3b_err",   32'(ge), 32'd1);
        chk("t3b_ecode", 32'(ecode1), 32'd1);
        chk("t3b_ecnt",  32'(ecnt1), 32'd2);
        chk("t3b_keep",  32'(frame1[7:0]), 32'h33);
        repeat (10) @(negedge clk);

        // Overlong, then valid frame with clk_en stall during the hold
        send_frame(1'b0, 53, 0);
        wait_outcome(1'b0, gw, ge);
        chk("t4_err",   32'(ge), 32'd1);
        chk("t4_ecode", 32'(ecode1), 32'd2);
        chk("t4_ecnt",  32'(ecnt1), 32'd3);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 64; i++) tx[i] = 8'(200 - i);
        seal_crc(FB);
        send_frame(1'b0, FB + XB, 0);
        wait_outcome(1'b0, gw, ge);
        chk("t4v_wr",     32'(gw), 32'd1);
        chk("t4v_ecode",  32'(ecode1), 32'd0);
        chk("t4v_byte0",  32'(frame1[407:400]), 32'hC8);
        chk("t4v_byte50", 32'(frame1[7:0]),     32'h96);
        chk("t4v_ecnt",   32'(ecnt1), 32'd3);
        clk_en = 1'b0;
        repeat (40) @(negedge clk);
        chk("t4v_hold_wr",  32'(wr1),  32'd1);
        chk("t4v_hold_upd", 32'(upd1), 32'd1);
        clk_en = 1'b1;
        measure_upd(1'b0, n);
        chk("t4v_upd_len", 32'(n), 32'd128);

`ifdef SPI_FRAME_CRC_EN
        // CRC accept / reject
        for (int i = 0; i < 64; i++) tx[i] = 8'(i * 5 + 1);
        seal_crc(FB);
        send_frame(1'b0, FB + 1, 0);
        wait_outcome(1'b0, gw, ge);
        chk("t5_crc_ok", 32'(gw), 32'd1);
        chk("t5_byte0",  32'(frame1[407:400]), 32'h01);
        repeat (10) @(negedge clk);
        tx[FB] = tx[FB] ^ 8'h01;
        send_frame(1'b0, FB + 1, 0);
        wait_outcome(1'b0, gw, ge);
        chk("t5_crc_err", 32'(ge), 32'd1);
        chk("t5_ecode",   32'(ecode1), 32'd3);
        chk("t5_ecnt",    32'(ecnt1), 32'd4);
        repeat (10) @(negedge clk);
`endif

        // Reset mid-frame, release while CS still low
        for (int i = 0; i < 64; i++) tx[i] = 8'(i * 3 + 7);
        seal_crc(FB);
        cs1 = 1'b0;
        repeat (HP1) @(negedge clk);
        for (int i = 0; i < 20; i++) send_bits(1'b0, tx[i], 8);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_rst_frame", 32'(frame1 != '0), 32'd0);
        chk("t6_rst_ecnt",  32'(ecnt1), 32'd0);
        rst_n = 1'b1;
        for (int i = 20; i < FB + XB; i++) send_bits(1'b0, tx[i], 8);
        repeat (HP1) @(negedge clk);
        cs1 = 1'b1;
        wait_outcome(1'b0, gw, ge);
        chk("t6_ign_wr",  32'(gw), 32'd0);
        chk("t6_ign_err", 32'(ge), 32'd0);
        chk("t6_ign_frame", 32'(frame1 != '0), 32'd0);
        repeat (10) @(negedge clk);
        send_frame(1'b0, FB + XB, 0);
        wait_outcome(1'b0, gw, ge);
        chk("t6_next_wr",     32'(gw), 32'd1);
        chk("t6_next_byte0",  32'(frame1[407:400]), 32'h07);
        chk("t6_next_byte50", 32'(frame1[7:0]),     32'h9D);
        chk("t6_next_ecnt",   32'(ecnt1), 32'd0);

        // Retrigger of the time flag on the 1-byte receiver
        tx[0] = 8'h5A;
        seal_crc(1);
        send_frame(1'b1, 1 + XB, 0);
        wait_outcome(1'b1, gw, ge);
        chk("t7a_wr",    32'(gw), 32'd1);
        chk("t7a_frame", 32'(frame2), 32'h5A);
        chk("t7a_upd",   32'(upd2), 32'd1);
        t_a  = cyc;
        mon2 = 1'b1;
        tx[0] = 8'hC3;
        seal_crc(1);
        send_frame(1'b1, 1 + XB, 0);
        wait_outcome(1'b1, gw, ge);
        mon2 = 1'b0;
        chk("t7b_wr",    32'(gw), 32'd1);
        chk("t7b_frame", 32'(frame2), 32'hC3);
        chk("t7b_upd",   32'(upd2), 32'd1);
`ifndef SPI_FRAME_CRC_EN
        chk("t7b_within_hold", 32'((cyc - t_a) < 128), 32'd1);
        chk("t7b_no_drop",     32'(upd2_low), 32'd0);
`endif
        measure_upd(1'b1, n);
        chk("t7b_upd_len", 32'(n), 32'd128);
        chk("t7_small_ferr",  32'(ferr2),  32'd0);
        chk("t7_small_ecode", 32'(ecode2), 32'd0);
        chk("t7_small_ecnt",  32'(ecnt2),  32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
